down_counter_timer: RTL and testbench



---
 rtl/counters_pkg.sv | 11 +
 rtl/down_counter_timer_if.sv | 26 ++
 rtl/down_counter_timer.sv | 80 ++++++++
 tb/tb_down_counter_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared constants and state encoding for the counter family
package counters_pkg;

  localparam int DEFAULT_BITS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control/status bundle between a timer client and the timer
interface down_counter_timer_if
  import counters_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
);

  logic [BITS-1:0] load_val;
  logic            start;
  logic            stop;
  logic            auto_reload;
  logic [BITS-1:0] Q;
  logic            tc;
  logic            busy;

  modport master (
    output load_val, start, stop, auto_reload,
    input  Q, tc, busy
  );

  modport slave (
    input  load_val, start, stop, auto_reload,
    output Q, tc, busy
  );

endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - programmable down-counting timer with one-shot and auto-reload modes
module down_counter_timer
  import counters_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  down_counter_timer_if.slave bus
);

  localparam logic [BITS-1:0] ZERO = '0;
  localparam logic [BITS-1:0] ONE  = BITS'(1);

  state_t          state, state_n;
  logic [BITS-1:0] q, q_n;
  logic [BITS-1:0] reload_reg, reload_n;
  logic            mode_reg, mode_n;
  logic            tc, tc_n;
  logic            busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      q          <= ZERO;
      reload_reg <= ZERO;
      mode_reg   <= 1'b0;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      reload_reg <= reload_n;
      mode_reg   <= mode_n;
      tc         <= tc_n;
      busy       <= (state_n == ST_RUN);
    end
  end

  // Priority is stop > start > count; zero is always handled explicitly so q never underflows.
  always_comb begin
    state_n  = state;
    q_n      = q;
    reload_n = reload_reg;
    mode_n   = mode_reg;
    tc_n     = 1'b0;

    if (bus.stop) begin
      state_n = ST_IDLE;
    end else if (bus.start) begin
      q_n      = bus.load_val;
      reload_n = bus.load_val;
      mode_n   = bus.auto_reload;
      if (bus.load_val != ZERO) begin
        state_n = ST_RUN;
      end else begin
        tc_n    = 1'b1;
        state_n = bus.auto_reload ? ST_RUN : ST_IDLE;
      end
    end else if (state == ST_RUN) begin
      if (q > ONE) begin
        q_n = q - ONE;
      end else if (q == ONE) begin
        q_n  = ZERO;
        tc_n = 1'b1;
        if (!mode_reg) state_n = ST_IDLE;
      end else if (mode_reg) begin
        q_n  = reload_reg;
        tc_n = (reload_reg == ZERO);
      end else begin
        state_n = ST_IDLE;
      end
    end
  end

  assign bus.Q    = q;
  assign bus.tc   = tc;
  assign bus.busy = busy;

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - self-checking bench: directed vector table, corner sequences, random vs. model
module tb_down_counter_timer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  down_counter_timer_if #(.BITS(8)) bus ();

  down_counter_timer #(.BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit       start;
    bit       stop;
    bit       ar;
    bit [7:0] load;
    int       q;
    bit       tc;
    bit       busy;
  } vec_t;

  vec_t vecs[$];

  // Reference: timeline position k since the last accepted start, evaluated arithmetically.
  int    m_n;
  longint m_k;
  bit    m_counting;
  bit    m_periodic;
  int    m_hold;
  int    m_q;
  bit    m_tc;
  bit    m_busy;

  task automatic model_reset();
    m_counting = 0; m_hold = 0; m_k = 0; m_n = 0; m_periodic = 0;
    m_q = 0; m_tc = 0; m_busy = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit a, input bit [7:0] lv);
    if (p) begin
      if (m_counting) begin
        m_hold = m_q;
        m_counting = 0;
      end
    end else if (s) begin
      m_n = int'(lv); m_periodic = a; m_k = 0; m_counting = 1;
    end else if (m_counting) begin
      m_k++;
    end
    if (m_counting) begin
      if (m_periodic) begin
        m_q    = m_n - int'(m_k % longint'(m_n + 1));
        m_tc   = (m_q == 0);
        m_busy = 1;
      end else begin
        m_q    = (m_k >= longint'(m_n)) ? 0 : m_n - int'(m_k);
        m_tc   = (m_k == longint'(m_n));
        m_busy = (m_k < longint'(m_n));
        if (m_k >= longint'(m_n)) begin
          m_counting = 0;
          m_hold = 0;
        end
      end
    end else begin
      m_q = m_hold; m_tc = 0; m_busy = 0;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input bit s, input bit p, input bit a, input bit [7:0] lv);
    @(negedge clk);
    bus.start = s; bus.stop = p; bus.auto_reload = a; bus.load_val = lv;
    @(posedge clk);
    model_edge(s, p, a, lv);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00);
  endtask

  task automatic add(input bit s, input bit p, input bit a, input int lv,
                     input int q, input bit tc, input bit busy);
    vec_t v;
    v.start = s; v.stop = p; v.ar = a; v.load = 8'(lv);
    v.q = q; v.tc = tc; v.busy = busy;
    vecs.push_back(v);
  endtask

  initial begin
    int tc_count;
    bit under;
    bus.start = 0; bus.stop = 0; bus.auto_reload = 0; bus.load_val = '0;
    model_reset();

    // one-shot load 3
    add(1,0,0,3, 3,0,1); add(0,0,0,0, 2,0,1); add(0,0,0,0, 1,0,1);
    add(0,0,0,0, 0,1,0); add(0,0,0,0, 0,0,0);
    // auto-reload load 2, then stop
    add(1,0,1,2, 2,0,1); add(0,0,0,0, 1,0,1); add(0,0,0,0, 0,1,1);
    add(0,0,0,0, 2,0,1); add(0,0,0,0, 1,0,1); add(0,0,0,0, 0,1,1);
    add(0,0,0,0, 2,0,1); add(0,1,0,0, 2,0,0); add(0,0,0,0, 2,0,0);
    // stop and priority
    add(1,0,0,5, 5,0,1); add(0,0,0,0, 4,0,1); add(0,0,0,0, 3,0,1);
    add(0,1,0,0, 3,0,0); add(0,0,0,0, 3,0,0); add(1,1,0,9, 3,0,0);
    add(1,0,0,5, 5,0,1); add(0,0,0,0, 4,0,1); add(1,0,0,4, 4,0,1);
    add(0,0,0,0, 3,0,1); add(1,1,1,9, 3,0,0); add(0,0,0,0, 3,0,0);
    // zero loads
    add(1,0,0,0, 0,1,0); add(0,0,0,0, 0,0,0); add(1,0,1,0, 0,1,1);
    add(0,0,0,0, 0,1,1); add(0,0,0,0, 0,1,1); add(0,1,0,0, 0,0,0);

    repeat (2) @(posedge clk);
    #2;
    chk("reset_q", int'(bus.Q), 0);
    chk("reset_tc", int'(bus.tc), 0);
    chk("reset_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].ar, vecs[i].load);
      chk($sformatf("vec%0d_q", i), int'(bus.Q), vecs[i].q);
      chk($sformatf("vec%0d_tc", i), int'(bus.tc), int'(vecs[i].tc));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].busy));
    end

    // reset mid-run: forced immediately, no tc afterward
    step(1, 0, 0, 8'd10);
    repeat (3) idle();
    chk("midrun_q_before", int'(bus.Q), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_q", int'(bus.Q), 0);
    chk("midrun_busy", int'(bus.busy), 0);
    chk("midrun_tc", int'(bus.tc), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      idle();
      chk("post_reset_q", int'(bus.Q), 0);
      chk("post_reset_tc", int'(bus.tc), 0);
    end

    // max load one-shot
    tc_count = 0; under = 0;
    step(1, 0, 0, 8'd255);
    chk("max_first_q", int'(bus.Q), 255);
    for (int k = 1; k <= 255; k++) begin
      idle();
      if (int'(bus.Q) != 255 - k) under = 1;
      if (bus.tc) tc_count++;
    end
    chk("max_sequence_ok", int'(under), 0);
    chk("max_tc_count", tc_count, 1);
    idle();
    chk("max_hold_q", int'(bus.Q), 0);
    chk("max_hold_busy", int'(bus.busy), 0);
    chk("max_hold_tc", int'(bus.tc), 0);

    // randomized against the reference model
    for (int i = 0; i < 3000; i++) begin
      bit s, p, a;
      bit [7:0] lv;
      s  = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 19) == 0);
      a  = $urandom_range(0, 1) == 1;
      lv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      step(s, p, a, lv);
      chk($sformatf("rnd%0d_q", i), int'(bus.Q), m_q);
      chk($sformatf("rnd%0d_tc", i), int'(bus.tc), int'(m_tc));
      chk($sformatf("rnd%0d_busy", i), int'(bus.busy), int'(m_busy));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
